pl_store_buffer: RTL and testbench
==================================

// Module: pl_store_buffer
// PURPOSE
//  Memory-access front end between the EXE/MEM pipeline register and a multi-cycle data memory.
//  Posts stores into a small FIFO and drains them in the background over a req/ack port.
//  Services loads directly from memory, or from the buffer when forwarding is enabled.
//  Drives a pipeline stall while a load is waiting for memory or while a store finds the buffer full.
// PARAMETERS
//  SB_DEPTH  4   store-buffer entries; power of 2, >=2
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  rst        in   1   synchronous reset, active-high
//  ld         in   1   load in MEM stage
//  st         in   1   store in MEM stage
//  addr       in   32  byte address; word access only; addr[1:0] ignored
//  wdata      in   32  store data
//  rdata      out  32  load result to MEM/WB; valid when ld & ~stall, else 0
//  stall      out  1   freeze upstream stages; ld/st/addr/wdata must be held stable while high
//  sb_empty   out  1   buffer empty and no write in flight (for sync/fence)
//  mem_req    out  1   memory request
//  mem_we     out  1   1 = write, 0 = read
//  mem_addr   out  32  word-aligned address ({addr[31:2],2'b00})
//  mem_wdata  out  32  write data
//  mem_rdata  in   32  read data, valid in the mem_ack cycle
//  mem_ack    in   1   completes the current request; single-cycle pulse
// BEHAVIOUR
//  Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, buffer empty, FSM=IDLE, sb_empty=1.
//  Reset values (cont.): stall=0, rdata=0.
//  Reset mid-request abandons the request. An mem_ack arriving with FSM=IDLE is ignored.
//  FSM states: IDLE, WR (drain write in flight), RD (load read in flight).
//   IDLE->RD  : ld & load miss (see below).
//   IDLE->WR  : buffer non-empty & no load miss; issues the head entry. A load miss wins over a drain.
//   WR->IDLE  : mem_ack; head is popped in the same edge.
//   RD->IDLE  : mem_ack; rdata=mem_rdata combinationally in the ack cycle; stall=0 in that cycle.
//  Request hold rule: mem_req/we/addr/wdata are registered and held stable from issue until mem_ack.
//   mem_req drops the cycle after ack unless a new request is issued on the same edge.
//  Load miss: ld with no forwarding hit.
//   stall=1 while FSM!=IDLE before issue, and while in RD until ack.
//   A load arriving during WR waits for the write ack, then issues its read on the next edge.
//  Store: enqueued on an edge where st & ~stall.
//   When full, stall=1 until a WR ack frees a slot. The enqueue is accepted in the ack cycle (pop+push together).
//   A store never waits on memory otherwise.
//  Address match compares addr[31:2] only. Full/empty use a count 0..SB_DEPTH; pointers wrap modulo SB_DEPTH.
//  ld & st together is illegal: st is ignored and a simulation assertion fires.
//  sb_empty = (count==0) & (FSM!=WR).
// CONFIGURATION
//  PL_SB_STORE_FWD_EN defined:
//   A load matching any buffered entry is a hit.
//   rdata = data of the youngest matching entry, same cycle, stall=0, no memory read.
//  PL_SB_STORE_FWD_EN undefined:
//   A load matching any entry stalls until sb_empty=1, then proceeds as a normal load miss.
// STRUCTURE
//  Package pl_mem_pkg:
//   typedef sb_entry_t {logic [29:0] waddr; logic [31:0] data;}
//   enum sb_state_t {IDLE, WR, RD}
//   SB_DEPTH_DEFAULT=4
//  Sub-module pl_sb_fifo:
//   circular buffer with push/pop/count and a parallel address match giving youngest-hit index + data.
//  Top holds the FSM, stall logic and memory port registers.
// TESTING
//  1 store 0x100=0xDEADBEEF, ack 3 cycles later
//    -> stall 0; next cycle mem_req=1, we=1, addr=0x100 held 3 cycles
//    -> sb_empty=1 the cycle after ack.
//  2 5 stores with mem_ack low
//    -> first 4 no stall; 5th stall=1 until first write ack, enqueued in ack cycle, count stays 4.
//  3 st 0x200=0x11111111, st 0x200=0x22222222, ld 0x200, ack low
//    -> FWD_EN: rdata=0x22222222, stall 0.
//    -> no macro: stall until both drained, then read issued.
//  4 ld 0x300 miss during a WR
//    -> stall until write ack, read req next edge
//    -> rdata=mem_rdata (0xCAFEF00D) at ack, stall drops that cycle.
//  5 buffer holds 2 entries, FSM IDLE, ld miss 0x400 -> read issued before any drain.
//  6 rst while mem_req=1 with 2 entries
//    -> next cycle mem_req 0, sb_empty 1, stall 0; late mem_ack causes no state change.

Source files
------------

// File: rtl/pl_mem_pkg.sv
// Shared types for the MEM-stage store buffer: entry layout, FSM states, default depth.
package pl_mem_pkg;

  localparam int unsigned SB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {IDLE, WR, RD} sb_state_t;

  function automatic logic [31:0] word_addr(input logic [29:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/pl_sb_fifo.sv
// Circular store buffer with push/pop and a parallel address match returning the youngest hit.
module pl_sb_fifo
  import pl_mem_pkg::*;
#(
  parameter int unsigned Depth = SB_DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  sb_entry_t   push_entry_i,
  input  logic        pop_i,
  input  logic [29:0] match_waddr_i,
  output sb_entry_t   head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        hit_o,
  output logic [31:0] hit_data_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  sb_entry_t             mem_q [Depth];
  logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [PtrW-1:0]       idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  // Push into a full buffer is only legal alongside a pop, so it overwrites the departing head.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

  // Scan oldest to youngest so the last valid match wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (mem_q[idx].waddr == match_waddr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[idx].data;
      end
    end
  end

endmodule

// File: rtl/pl_store_buffer.sv
// MEM-stage front end: posted store buffer draining over req/ack, load reads, pipeline stall.
// Optional store-to-load forwarding enabled by defining PL_SB_STORE_FWD_EN.
module pl_store_buffer
  import pl_mem_pkg::*;
#(
  parameter int unsigned SB_DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_i,
  input  logic        st_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        sb_empty_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  sb_state_t   state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  sb_entry_t   in_entry, head, drain_entry;
  logic        push, pop, fifo_full, fifo_empty, match_hit;
  logic [31:0] match_data;
  logic        fwd_hit, ld_blocked, ld_miss, wr_ack, rd_ack;
  logic        unused_addr;

  assign unused_addr = ^addr_i[1:0];
  assign in_entry    = '{waddr: addr_i[31:2], data: wdata_i};

  pl_sb_fifo #(
    .Depth (SB_DEPTH)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (push),
    .push_entry_i  (in_entry),
    .pop_i         (pop),
    .match_waddr_i (addr_i[31:2]),
    .head_o        (head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .hit_o         (match_hit),
    .hit_data_o    (match_data)
  );

  assign sb_empty_o = fifo_empty & (state_q != WR);

`ifdef PL_SB_STORE_FWD_EN
  assign fwd_hit    = ld_i & match_hit;
  assign ld_blocked = 1'b0;
`else
  logic unused_match_data;
  assign unused_match_data = ^match_data;
  assign fwd_hit    = 1'b0;
  // A load overlapping buffered stores waits for the buffer to drain completely.
  assign ld_blocked = match_hit & ~sb_empty_o;
`endif

  assign ld_miss = ld_i & ~fwd_hit & ~ld_blocked;
  assign wr_ack  = (state_q == WR) & mem_ack_i;
  assign rd_ack  = (state_q == RD) & mem_ack_i;

  always_comb begin
    stall_o = 1'b0;
    if (ld_i)      stall_o = ~(fwd_hit | rd_ack);
    else if (st_i) stall_o = fifo_full & ~wr_ack;
  end

  // A simultaneous st is dropped; the load owns the cycle.
  assign push = st_i & ~ld_i & ~stall_o;
  assign pop  = wr_ack;

  always_comb begin
    rdata_o = '0;
    if (ld_i & ~stall_o) rdata_o = fwd_hit ? match_data : mem_rdata_i;
  end

  // An empty buffer drains the incoming store straight away instead of waiting a cycle.
  assign drain_entry = fifo_empty ? in_entry : head;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (ld_miss) begin
          state_d     = RD;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {addr_i[31:2], 2'b00};
          mem_wdata_d = '0;
        end else if (~fifo_empty | push) begin
          state_d     = WR;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = word_addr(drain_entry.waddr);
          mem_wdata_d = drain_entry.data;
        end
      end
      WR, RD: begin
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  ld_st_exclusive_a: assert property (@(posedge clk_i) disable iff (rst_i) !(ld_i && st_i));

endmodule

// File: tb/tb_pl_store_buffer.sv
// Directed bench for pl_store_buffer: cycle vectors plus hand-written multi-cycle sequences.
module tb_pl_store_buffer;

  logic        clk = 1'b0;
  logic        rst, ld, st, mem_ack;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        stall, sb_empty, mem_req, mem_we;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pl_store_buffer #(
    .SB_DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ld_i        (ld),
    .st_i        (st),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .stall_o     (stall),
    .sb_empty_o  (sb_empty),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  typedef struct {
    string       nm;
    logic        rst, ld, st;
    logic [31:0] addr, wdata;
    logic        ack;
    logic [31:0] mrd;
    logic        e_stall;
    logic [31:0] e_rdata;
    logic        e_empty, e_req, e_we;
    logic [31:0] e_maddr, e_wdata;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  function automatic vec_t mk(input string nm, input logic r, input logic l, input logic s,
                              input logic [31:0] a, input logic [31:0] wd, input logic ak,
                              input logic [31:0] mrd, input logic es, input logic [31:0] er,
                              input logic ee, input logic eq, input logic ew,
                              input logic [31:0] ea, input logic [31:0] ed);
    vec_t v;
    v.nm = nm; v.rst = r; v.ld = l; v.st = s; v.addr = a; v.wdata = wd; v.ack = ak;
    v.mrd = mrd; v.e_stall = es; v.e_rdata = er; v.e_empty = ee; v.e_req = eq;
    v.e_we = ew; v.e_maddr = ea; v.e_wdata = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance past the next edge.
  task automatic apply(input vec_t v);
    rst = v.rst; ld = v.ld; st = v.st; addr = v.addr; wdata = v.wdata;
    mem_ack = v.ack; mem_rdata = v.mrd;
    @(negedge clk);
    chk({v.nm, ".stall"}, {31'd0, stall}, {31'd0, v.e_stall});
    chk({v.nm, ".rdata"}, rdata, v.e_rdata);
    chk({v.nm, ".sb_empty"}, {31'd0, sb_empty}, {31'd0, v.e_empty});
    chk({v.nm, ".mem_req"}, {31'd0, mem_req}, {31'd0, v.e_req});
    if (v.e_req) begin
      chk({v.nm, ".mem_we"}, {31'd0, mem_we}, {31'd0, v.e_we});
      chk({v.nm, ".mem_addr"}, mem_addr, v.e_maddr);
      if (v.e_we) chk({v.nm, ".mem_wdata"}, mem_wdata, v.e_wdata);
    end
    @(posedge clk);
    #1;
  endtask

  // Ack every write in turn, checking it against exp_a/exp_d, until the buffer is empty.
  task automatic drain(input string nm);
    int guard = 0;
    rst = 1'b0; ld = 1'b0; st = 1'b0; mem_ack = 1'b0;
    while (!(sb_empty && exp_a.size() == 0) && guard < 40) begin
      @(negedge clk);
      if (mem_req && mem_we && exp_a.size() > 0) begin
        chk({nm, ".drain_addr"}, mem_addr, exp_a.pop_front());
        chk({nm, ".drain_data"}, mem_wdata, exp_d.pop_front());
        mem_ack = 1'b1;
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      guard++;
    end
    n_vec++;
    if (!(sb_empty && exp_a.size() == 0)) begin
      n_err++;
      $display("FAIL %s.drain_timeout: sb_empty %0b, %0d writes outstanding", nm, sb_empty,
               exp_a.size());
      exp_a.delete();
      exp_d.delete();
    end
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; st = 1'b0; addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    // nm, rst ld st addr wdata ack mrd | stall rdata empty req we maddr mwdata
    tbl.push_back(mk("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("s1c0", 0, 0, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("s1c1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF));
    tbl.push_back(mk("s1c2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF));
    tbl.push_back(mk("s1c3", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF));
    tbl.push_back(mk("s1c4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("s2c0", 0, 0, 1, 32'h1000, 32'hA0000000, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("s2c1", 0, 0, 1, 32'h1004, 32'hA0000001, 0, 0, 0, 0, 0, 1, 1, 32'h1000,
                     32'hA0000000));
    tbl.push_back(mk("s2c2", 0, 0, 1, 32'h1008, 32'hA0000002, 0, 0, 0, 0, 0, 1, 1, 32'h1000,
                     32'hA0000000));
    tbl.push_back(mk("s2c3", 0, 0, 1, 32'h100E, 32'hA0000003, 0, 0, 0, 0, 0, 1, 1, 32'h1000,
                     32'hA0000000));
    tbl.push_back(mk("s2c4", 0, 0, 1, 32'h1010, 32'hA0000004, 0, 0, 1, 0, 0, 1, 1, 32'h1000,
                     32'hA0000000));
    tbl.push_back(mk("s2c5", 0, 0, 1, 32'h1010, 32'hA0000004, 0, 0, 1, 0, 0, 1, 1, 32'h1000,
                     32'hA0000000));
    tbl.push_back(mk("s2c6", 0, 0, 1, 32'h1010, 32'hA0000004, 1, 0, 0, 0, 0, 1, 1, 32'h1000,
                     32'hA0000000));
    tbl.push_back(mk("s2c7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("s2c8", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1004, 32'hA0000001));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      if (tbl[i].nm == "rst1") begin
        chk("rst.mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
      end
    end
    // Byte offset 0x100E must land as word 0x100C; the 5th store sits behind entries 1..3.
    exp_a = '{32'h1004, 32'h1008, 32'h100C, 32'h1010};
    exp_d = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
    drain("s2");

    // Two stores to one address, then a load of it with the memory not acking.
    apply(mk("s3c0", 0, 0, 1, 32'h200, 32'h11111111, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    apply(mk("s3c1", 0, 0, 1, 32'h200, 32'h22222222, 0, 0, 0, 0, 0, 1, 1, 32'h200,
             32'h11111111));
`ifdef PL_SB_STORE_FWD_EN
    apply(mk("s3c2", 0, 1, 0, 32'h200, 0, 0, 32'h0BADBAD0, 0, 32'h22222222, 0, 1, 1, 32'h200,
             32'h11111111));
    exp_a = '{32'h200, 32'h200};
    exp_d = '{32'h11111111, 32'h22222222};
    drain("s3");
`else
    apply(mk("s3c2", 0, 1, 0, 32'h200, 0, 0, 0, 1, 0, 0, 1, 1, 32'h200, 32'h11111111));
    apply(mk("s3c3", 0, 1, 0, 32'h200, 0, 1, 0, 1, 0, 0, 1, 1, 32'h200, 32'h11111111));
    apply(mk("s3c4", 0, 1, 0, 32'h200, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply(mk("s3c5", 0, 1, 0, 32'h200, 0, 0, 0, 1, 0, 0, 1, 1, 32'h200, 32'h22222222));
    apply(mk("s3c6", 0, 1, 0, 32'h200, 0, 1, 0, 1, 0, 0, 1, 1, 32'h200, 32'h22222222));
    apply(mk("s3c7", 0, 1, 0, 32'h200, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    apply(mk("s3c8", 0, 1, 0, 32'h200, 0, 1, 32'h12345678, 0, 32'h12345678, 1, 1, 0, 32'h200,
             0));
    apply(mk("s3c9", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
`endif

    // Load miss arriving while a write is in flight.
    apply(mk("s4c0", 0, 0, 1, 32'h500, 32'h55, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    apply(mk("s4c1", 0, 1, 0, 32'h300, 0, 0, 0, 1, 0, 0, 1, 1, 32'h500, 32'h55));
    apply(mk("s4c2", 0, 1, 0, 32'h300, 0, 1, 0, 1, 0, 0, 1, 1, 32'h500, 32'h55));
    apply(mk("s4c3", 0, 1, 0, 32'h300, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    apply(mk("s4c4", 0, 1, 0, 32'h300, 0, 0, 0, 1, 0, 1, 1, 0, 32'h300, 0));
    apply(mk("s4c5", 0, 1, 0, 32'h300, 0, 1, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1, 1, 0, 32'h300,
             0));
    apply(mk("s4c6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // Two entries buffered with the FSM idle: the load read goes out first.
    apply(mk("s5c0", 0, 0, 1, 32'h600, 32'hB0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    apply(mk("s5c1", 0, 0, 1, 32'h604, 32'hB1, 0, 0, 0, 0, 0, 1, 1, 32'h600, 32'hB0));
    apply(mk("s5c2", 0, 0, 1, 32'h608, 32'hB2, 0, 0, 0, 0, 0, 1, 1, 32'h600, 32'hB0));
    apply(mk("s5c3", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h600, 32'hB0));
    apply(mk("s5c4", 0, 1, 0, 32'h400, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply(mk("s5c5", 0, 1, 0, 32'h400, 0, 1, 32'h44, 0, 32'h44, 0, 1, 0, 32'h400, 0));
    apply(mk("s5c6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("s5c7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h604, 32'hB1));
    exp_a = '{32'h604, 32'h608};
    exp_d = '{32'hB1, 32'hB2};
    drain("s5");

    // Reset with a write in flight and two entries, then a stray ack.
    apply(mk("s6c0", 0, 0, 1, 32'h700, 32'h70, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    apply(mk("s6c1", 0, 0, 1, 32'h704, 32'h71, 0, 0, 0, 0, 0, 1, 1, 32'h700, 32'h70));
    apply(mk("s6c2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h700, 32'h70));
    apply(mk("s6c3", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    apply(mk("s6c4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    apply(mk("s6c5", 0, 0, 1, 32'h800, 32'h80, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    apply(mk("s6c6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h800, 32'h80));
    exp_a = '{32'h800};
    exp_d = '{32'h80};
    drain("s6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
